cordic_sincos: RTL

Iterative, parametrised CORDIC rotation unit. It takes an IEEE-754 single-precision angle in radians and returns both cos and sin as IEEE-754 singles. It succeeds the fixed 8-step cosine unit: iteration count, fraction width and iterations-per-cycle are now configurable, it produces a sine output, and it flags out-of-range and non-finite inputs. It sits behind the custom-instruction interface in the same slot as the cosine unit and keeps its start/done handshake.

---
 rtl/cordic_pkg.sv | 57 +++++
 rtl/cordic_sincos_if.sv | 20 ++
 rtl/cordic_stage.sv | 37 +++
 rtl/cordic_sincos.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC sin/cos unit: atan and gain tables, FSM states,
// IEEE-754 single-precision field layout.
package cordic_pkg;

    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    // Largest single-precision magnitude strictly below pi/2 (0x3FC90FDB rounds above it).
    localparam logic [30:0] HALF_PI_ABS_MAX = 31'h3FC9_0FDA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROTATE,
        ST_PACK
    } state_t;

    // atan(2^-i) in Q2.30, truncated.
    function automatic logic [31:0] atan_q30(input logic [4:0] i);
        logic [31:0] r;
        case (i)
            5'd0:    r = 32'h3243_F6A8;
            5'd1:    r = 32'h1DAC_6705;
            5'd2:    r = 32'h0FAD_BAFC;
            5'd3:    r = 32'h07F5_6EA6;
            5'd4:    r = 32'h03FE_AB76;
            5'd5:    r = 32'h01FF_D55B;
            5'd6:    r = 32'h00FF_FAAA;
            5'd7:    r = 32'h007F_FF55;
            5'd8:    r = 32'h003F_FFEA;
            5'd9:    r = 32'h001F_FFFD;
            5'd10:   r = 32'h000F_FFFF;
            5'd31:   r = 32'h0000_0000;
            // beyond i=10 atan(2^-i) sits just under 2^-i, so truncation gives 2^(30-i)-1
            default: r = (32'd1 << (5'd30 - i)) - 32'd1;
        endcase
        return r;
    endfunction

    // Aggregate gain K(n) = prod_{i<n} 1/sqrt(1+2^-2i) in Q2.30, truncated.
    function automatic logic [31:0] k_q30(input int n);
        logic [31:0] r;
        case (n)
            8:       r = 32'd652039506;
            9:       r = 32'd652034532;
            10:      r = 32'd652033288;
            11:      r = 32'd652032977;
            12:      r = 32'd652032899;
            13:      r = 32'd652032880;
            14:      r = 32'd652032875;
            default: r = 32'd652032874;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_sincos_if.sv
// Start/done custom-instruction handshake and result bus of the CORDIC unit.
interface cordic_sincos_if;
    logic        start;
    logic [31:0] angle;
    logic        done;
    logic        busy;
    logic        range_err;
    logic [31:0] result_cos;
    logic [31:0] result_sin;

    modport master (
        output start, angle,
        input  done, busy, range_err, result_cos, result_sin
    );

    modport slave (
        input  start, angle,
        output done, busy, range_err, result_cos, result_sin
    );
endinterface

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in Q2.FRAC_W; shift index selects the step.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int FRAC_W = 30
) (
    input  logic signed [FRAC_W+2:0] x_i,
    input  logic signed [FRAC_W+2:0] y_i,
    input  logic signed [FRAC_W+2:0] z_i,
    input  logic        [4:0]        idx_i,
    output logic signed [FRAC_W+2:0] x_o,
    output logic signed [FRAC_W+2:0] y_o,
    output logic signed [FRAC_W+2:0] z_o
);
    localparam int W = FRAC_W + 3;

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [W-1:0] atan_fx;

    assign x_sh    = x_i >>> idx_i;
    assign y_sh    = y_i >>> idx_i;
    assign atan_fx = $signed(W'(atan_q30(idx_i) >> (30 - FRAC_W)));

    always_comb begin
        if (!z_i[W-1]) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_fx;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_fx;
        end
    end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC sin/cos of a single-precision angle; result_sin is only built
// when CORDIC_SIN_EN is defined, otherwise it reads 0.
//   state     | meaning
//   ST_IDLE   | waiting for start, angle captured on accept
//   ST_LOAD   | float->fixed, range check, x/y/counter init
//   ST_ROTATE | IPC micro-rotations per enabled edge
//   ST_PACK   | fixed->float, results registered, done pulsed
module cordic_sincos
    import cordic_pkg::*;
#(
    parameter int FRAC_W = 30,
    parameter int ITERS  = 16,
    parameter int IPC    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_en,
    cordic_sincos_if.slave bus
);
    localparam int W = FRAC_W + 3;
    localparam logic signed [W-1:0] K_INIT = $signed(W'(k_q30(ITERS) >> (30 - FRAC_W)));
    localparam logic [4:0] STEP = 5'(IPC);
    localparam logic [4:0] LAST = 5'(ITERS);

    function automatic logic signed [W-1:0] fp_to_fx(input logic [31:0] f);
        logic [7:0]          e;
        logic [FRAC_W+23:0]  wide;
        logic [W-1:0]        mag;
        e = f[FP_MAN_W +: FP_EXP_W];
        if (e == 8'd0 || int'(e) > FP_BIAS + FP_MAN_W) return '0;
        wide = {1'b1, f[FP_MAN_W-1:0], {FRAC_W{1'b0}}} >> (FP_BIAS + FP_MAN_W - int'(e));
        mag  = wide[W-1:0];
        return f[31] ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic [31:0] fx_to_fp(input logic signed [W-1:0] v);
        logic [W-1:0]  mag;
        logic [W+23:0] ext;
        int            msb;
        mag = v[W-1] ? $unsigned(-v) : $unsigned(v);
        if (mag == '0) return 32'h0;
        msb = 0;
        for (int b = 0; b < W; b++) begin
            if (mag[b]) msb = b;
        end
        ext = {mag, 24'd0} << (W - 1 - msb);
        return {v[W-1], 8'(FP_BIAS - FRAC_W + msb), ext[W+22 -: FP_MAN_W]};
    endfunction

    state_t              state_q, state_d;
    logic [31:0]         angle_q, angle_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic signed [W-1:0] z_q, z_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                range_err_q, range_err_d;
    logic [31:0]         cos_q, cos_d;
`ifdef CORDIC_SIN_EN
    logic [31:0]         sin_q, sin_d;
`endif

    logic signed [W-1:0] z_load;
    logic                load_err;
    logic signed [W-1:0] x_c [IPC+1];
    logic signed [W-1:0] y_c [IPC+1];
    logic signed [W-1:0] z_c [IPC+1];

    assign z_load   = fp_to_fx(angle_q);
    assign load_err = angle_q[30:0] > HALF_PI_ABS_MAX;

    assign x_c[0] = x_q;
    assign y_c[0] = y_q;
    assign z_c[0] = z_q;

    for (genvar k = 0; k < IPC; k++) begin : g_stage
        cordic_stage #(.FRAC_W(FRAC_W)) u_stage (
            .x_i   (x_c[k]),
            .y_i   (y_c[k]),
            .z_i   (z_c[k]),
            .idx_i (cnt_q + 5'(k)),
            .x_o   (x_c[k+1]),
            .y_o   (y_c[k+1]),
            .z_o   (z_c[k+1])
        );
    end

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        range_err_d = range_err_q;
        cos_d       = cos_q;
`ifdef CORDIC_SIN_EN
        sin_d       = sin_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    angle_d = bus.angle;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                z_d     = z_load;
                err_d   = load_err;
                x_d     = K_INIT;
                y_d     = '0;
                cnt_d   = '0;
                state_d = ST_ROTATE;
            end
            ST_ROTATE: begin
                x_d   = x_c[IPC];
                y_d   = y_c[IPC];
                z_d   = z_c[IPC];
                cnt_d = cnt_q + STEP;
                if (cnt_d == LAST) state_d = ST_PACK;
            end
            ST_PACK: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                range_err_d = err_q;
                cos_d       = err_q ? 32'h0 : fx_to_fp(x_q);
`ifdef CORDIC_SIN_EN
                sin_d       = err_q ? 32'h0 : fx_to_fp(y_q);
`endif
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            angle_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            range_err_q <= 1'b0;
            cos_q       <= '0;
`ifdef CORDIC_SIN_EN
            sin_q       <= '0;
`endif
        end else if (clk_en) begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            range_err_q <= range_err_d;
            cos_q       <= cos_d;
`ifdef CORDIC_SIN_EN
            sin_q       <= sin_d;
`endif
        end
    end

    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.range_err  = range_err_q;
    assign bus.result_cos = cos_q;
`ifdef CORDIC_SIN_EN
    assign bus.result_sin = sin_q;
`else
    assign bus.result_sin = 32'h0;
`endif

endmodule
